// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Multi-cycle unsigned 32x32 multiply (MULTU, shift-add) and
//             32/32 divide (DIVU, restoring) sequenced on the shared CPU ALU,
//             one iteration per cycle. Holds the HI/LO result registers.
//  Ports    : clk, rst_n (sync, active-low)
//             start/op/operand_a/operand_b : operation request (op 0=MULTU, 1=DIVU)
//             busy/done/hi/lo              : status and results
//             alu_own/alu_src_a/alu_src_b/alu_control : ALU drive
//             alu_result                   : combinational ALU result
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int          ITERATIONS = 32,
    parameter logic [31:0] DIV0_LO    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_own,
    output logic [31:0] alu_src_a,
    output logic [31:0] alu_src_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result
);

    localparam int             c_CNT_W   = $clog2(ITERATIONS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ITERATIONS - 1);
    localparam logic [3:0]     c_ALU_ADD = 4'b0010;
    localparam logic [3:0]     c_ALU_SUB = 4'b0110;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_b;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic               r_done;

    logic [31:0] w_rem;
    logic        w_carry;
    logic        w_div_ge;
    logic        w_last;

    // Partial remainder: the top bit shifted out of hi (hi[31]) is the 33rd
    // bit, so when it is set the remainder is certainly >= B and the 32-bit
    // ALU difference is still the exact result.
    assign w_rem    = {r_hi[30:0], r_lo[31]};
    assign w_div_ge = r_hi[31] | (w_rem >= r_b);
    // Unsigned add overflowed iff the sum wrapped below one of its operands.
    assign w_carry  = (alu_result < r_hi);
    assign w_last   = (r_count == c_LAST);

    always_comb begin
        alu_src_a   = 32'd0;
        alu_src_b   = 32'd0;
        alu_control = c_ALU_ADD;
        case (r_state)
            S_MUL: begin
                alu_src_a   = r_hi;
                alu_src_b   = r_lo[0] ? r_b : 32'd0;
                alu_control = c_ALU_ADD;
            end
            S_DIV: begin
                alu_src_a   = w_rem;
                alu_src_b   = r_b;
                alu_control = c_ALU_SUB;
            end
            default: begin
                alu_src_a   = 32'd0;
                alu_src_b   = 32'd0;
                alu_control = c_ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_b     <= 32'd0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (!op || (operand_b != 32'd0)) begin
                            r_hi    <= 32'd0;
                            r_lo    <= operand_a;
                            r_b     <= operand_b;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= op ? S_DIV : S_MUL;
                        end else begin
                            // Divide by zero finishes immediately.
                            r_hi    <= operand_a;
                            r_lo    <= DIV0_LO;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    // 65-bit {carry, sum, lo} shifted right by one.
                    {r_hi, r_lo} <= {w_carry, alu_result, r_lo[31:1]};
                    r_count      <= r_count + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_hi    <= w_div_ge ? alu_result : w_rem;
                    r_lo    <= {r_lo[30:0], w_div_ge};
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // DONE: single-cycle pulse, start ignored.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign alu_own = r_busy;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire
